ysyx_24100005_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_24100005_mem_arbiter
// PURPOSE
//  Shares the single npc memory port (DPI npcmem_read/npcmem_write wrapper) between
//  the instruction-fetch unit (IFU) and the load/store unit (LSU).
//  Sequences one transaction at a time with valid/ready request handshakes and
//  registered one-cycle response pulses. Round-robin grant on contention; a watchdog
//  terminates transactions the memory never answers.
//  Sits between the core (IFU/LSU) and the memory wrapper module.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width; wmask width = DW/8
//  TIMEOUT_CYC  16  max cycles in WAIT before an error response is generated (>=2)
// PORTS
//  clk            in   1     clock, all state updates on rising edge
//  rst            in   1     asynchronous reset, active high
//  ifu_req_valid  in   1     IFU read request (IFU never writes)
//  ifu_req_ready  out  1     IFU request accepted this cycle when valid&&ready
//  ifu_addr       in   AW    IFU fetch address
//  ifu_rsp_valid  out  1     one-cycle pulse: response for IFU on rsp_rdata
//  lsu_req_valid  in   1     LSU request
//  lsu_req_ready  out  1     LSU request accepted this cycle when valid&&ready
//  lsu_addr       in   AW    LSU address
//  lsu_wen        in   1     1 = write, 0 = read
//  lsu_wdata      in   DW    write data
//  lsu_wmask      in   DW/8  byte write mask
//  lsu_rsp_valid  out  1     one-cycle pulse: response for LSU on rsp_rdata
//  rsp_rdata      out  DW    shared response data, valid with either rsp_valid
//  rsp_err        out  1     with rsp_valid: 1 = timeout, rsp_rdata = 0
//  mem_req_valid  out  1     request to memory wrapper
//  mem_req_ready  in   1     memory accepts request when valid&&ready
//  mem_addr       out  AW    latched address
//  mem_wen        out  1     latched write enable
//  mem_wdata      out  DW    latched write data
//  mem_wmask      out  DW/8  latched write mask (0 for IFU/reads)
//  mem_rsp_valid  in   1     memory response (reads and write acks)
//  mem_rdata      in   DW    memory read data
//  busy           out  1     1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, last_grant=LSU (IFU wins first tie), counter 0.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE; one transaction in flight max.
//  IDLE: grant = sole requester; both valid -> requester != last_grant.
//   *_req_ready is combinational, high only for the granted requester, only in IDLE.
//   On handshake: latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0), owner, update
//   last_grant, go ISSUE. No valid -> stay IDLE, nothing latched.
//  ISSUE: mem_req_valid=1, mem_* stable from latches; mem_req_ready=1 -> WAIT, cnt=0.
//   mem_req_ready low -> hold indefinitely (no timeout in ISSUE).
//  WAIT: mem_req_valid=0; cnt++ each cycle. mem_rsp_valid=1 -> next cycle owner's
//   rsp_valid=1, rsp_rdata=mem_rdata, rsp_err=0, state IDLE.
//   cnt==TIMEOUT_CYC-1 without mem_rsp_valid -> next cycle owner's rsp_valid=1,
//   rsp_err=1, rsp_rdata=0, state IDLE. Response on the timeout cycle itself wins.
//  rsp_valid/rsp_err are exactly one cycle wide; rsp_rdata holds until next response.
//  Response cycle is IDLE: a new request may handshake the same cycle (back-to-back).
//  Latency: accept t, mem_req_valid t+1; mem ready at t+1 and rsp at t+2 -> rsp_valid t+3.
//  mem_rsp_valid while IDLE/ISSUE: ignored, no response, no state change.
//  Requester dropping valid before handshake: legal, nothing latched.
//  Write responses: rsp_rdata = mem_rdata as delivered (don't-care to LSU).
//  Reset mid-transaction: immediate return to reset state; in-flight op dropped,
//   no response pulse generated after reset release.
// TESTING
//  IFU read 0x8000_0000, mem ready at once, rsp 0x0000_0413 next -> ifu_rsp_valid
//   3 cycles after accept, rsp_rdata=0x0000_0413, err=0, lsu_rsp_valid stays 0.
//  IFU+LSU valid same cycle after reset, held -> IFU granted first, LSU second, then
//   alternating on continued contention.
//  LSU write addr 0x8000_0100 data 0xA5A5_A5A5 mask 4'b0011, mem_req_ready low 5
//   cycles -> mem_* stable through ISSUE, lsu_rsp_valid after mem_rsp_valid.
//  No mem_rsp_valid, TIMEOUT_CYC=16 -> 16 WAIT cycles, then rsp_valid with rsp_err=1,
//   rsp_rdata=0; busy drops same cycle.
//  Stray mem_rsp_valid in IDLE -> no rsp pulse; rst asserted in WAIT -> outputs 0
//   immediately, no response after release, next request served normally.

Source files
------------

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Arbitrates the single npc memory port between IFU fetches and LSU loads/stores.
// One transaction in flight, round-robin on contention, watchdog on unanswered requests.
//
// state  | meaning
// IDLE   | no transaction; grant requester, latch request on handshake
// ISSUE  | mem_req_valid high with latched request until memory accepts
// WAIT   | awaiting mem_rsp_valid; watchdog counts cycles toward timeout
module ysyx_24100005_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [AW-1:0]     ifu_addr,
    output logic              ifu_rsp_valid,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [AW-1:0]     lsu_addr,
    input  logic              lsu_wen,
    input  logic [DW-1:0]     lsu_wdata,
    input  logic [DW/8-1:0]   lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_wen,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_lsu;
    logic            owner_lsu;
    logic [CW-1:0]   cnt;
    logic            ifu_win;
    logic            lsu_win;
    logic            ifu_hs;
    logic            lsu_hs;
    logic            timeout;

    // IFU wins a tie only when the LSU was served last
    assign ifu_win       = ifu_req_valid && (!lsu_req_valid || last_lsu);
    assign lsu_win       = lsu_req_valid && !ifu_win;
    assign ifu_req_ready = (state == S_IDLE) && ifu_win;
    assign lsu_req_ready = (state == S_IDLE) && lsu_win;
    assign ifu_hs        = ifu_req_valid && ifu_req_ready;
    assign lsu_hs        = lsu_req_valid && lsu_req_ready;
    assign timeout       = (cnt == CW'(TIMEOUT_CYC - 1));
    assign mem_req_valid = (state == S_ISSUE);
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ifu_hs || lsu_hs)          state_nxt = S_ISSUE;
            S_ISSUE: if (mem_req_ready)             state_nxt = S_WAIT;
            S_WAIT:  if (mem_rsp_valid || timeout)  state_nxt = S_IDLE;
            default:                                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_lsu      <= 1'b1;
            owner_lsu     <= 1'b0;
            cnt           <= '0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            rsp_err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (lsu_hs) begin
                        mem_addr  <= lsu_addr;
                        mem_wen   <= lsu_wen;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                        owner_lsu <= 1'b1;
                        last_lsu  <= 1'b1;
                    end else if (ifu_hs) begin
                        mem_addr  <= ifu_addr;
                        mem_wen   <= 1'b0;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        owner_lsu <= 1'b0;
                        last_lsu  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) cnt <= '0;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // a response arriving on the timeout cycle still counts as a response
                    if (mem_rsp_valid) begin
                        ifu_rsp_valid <= !owner_lsu;
                        lsu_rsp_valid <= owner_lsu;
                        rsp_rdata     <= mem_rdata;
                    end else if (timeout) begin
                        ifu_rsp_valid <= !owner_lsu;
                        lsu_rsp_valid <= owner_lsu;
                        rsp_err       <= 1'b1;
                        rsp_rdata     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: grant order, latency, hold, timeout, reset.
module tb_ysyx_24100005_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_24100005_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called in ISSUE: memory accepts at once and answers in the first WAIT cycle;
    // returns in the response (IDLE) cycle
    task automatic mem_serve(input logic [31:0] d);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = d;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        do_reset();

        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_pulses", {29'b0, ifu_rsp_valid, lsu_rsp_valid, rsp_err}, 32'd0);

        // IFU read, 3-cycle latency
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #1;
        chk("t1_ifu_ready", {31'b0, ifu_req_ready}, 32'd1);
        tick();
        ifu_req_valid = 0; ifu_addr = 32'h0;
        #1;
        chk("t1_mem_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk("t1_mem_wen_wmask", {27'b0, mem_wen, mem_wmask}, 32'd0);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        mem_serve(32'h0000_0413);
        chk("t1_ifu_rsp", {31'b0, ifu_rsp_valid}, 32'd1);
        chk("t1_rdata", rsp_rdata, 32'h0000_0413);
        chk("t1_err_lsu", {30'b0, rsp_err, lsu_rsp_valid}, 32'd0);
        chk("t1_busy_done", {31'b0, busy}, 32'd0);
        tick();
        chk("t1_pulse_width", {31'b0, ifu_rsp_valid}, 32'd0);
        chk("t1_rdata_hold", rsp_rdata, 32'h0000_0413);

        // contention: IFU first after reset, then alternate
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0;
        #1;
        chk("t2_first_grant", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b10);
        tick();
        #1;
        chk("t2_issue_no_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b00);
        chk("t2_issue_addr_ifu", mem_addr, 32'h8000_0010);
        mem_serve(32'h0000_0011);
        chk("t2_rsp_ifu", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 32'b10);
        chk("t2_second_grant", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b01);
        tick();
        #1;
        chk("t2_issue_addr_lsu", mem_addr, 32'h8000_0200);
        mem_serve(32'h0000_0022);
        chk("t2_rsp_lsu", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 32'b01);
        chk("t2_rsp_lsu_data", rsp_rdata, 32'h0000_0022);
        chk("t2_third_grant", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b10);
        tick();
        #1;
        chk("t2_issue_addr_ifu2", mem_addr, 32'h8000_0010);
        mem_serve(32'h0000_0033);
        chk("t2_fourth_grant", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b01);
        ifu_req_valid = 0; lsu_req_valid = 0;
        #1;
        chk("t2_drop_no_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b00);
        tick();
        chk("t2_drop_idle", {31'b0, busy}, 32'd0);

        // LSU write with memory stalling ISSUE; stray responses ignored in ISSUE
        lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1;
        lsu_wdata = 32'hA5A5_A5A5; lsu_wmask = 4'b0011;
        tick();
        lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wen = 0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_valid", {31'b0, mem_req_valid}, 32'd1);
            chk("t3_hold_addr", mem_addr, 32'h8000_0100);
            chk("t3_hold_wdata", mem_wdata, 32'hA5A5_A5A5);
            chk("t3_hold_wen_wmask", {27'b0, mem_wen, mem_wmask}, {27'b0, 1'b1, 4'b0011});
            chk("t3_hold_no_rsp", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
            tick();
        end
        mem_rsp_valid = 0;
        mem_serve(32'h0000_DEAD);
        chk("t3_lsu_rsp", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 32'b01);
        chk("t3_lsu_rdata", rsp_rdata, 32'h0000_DEAD);
        chk("t3_lsu_err", {31'b0, rsp_err}, 32'd0);

        // timeout after 16 silent WAIT cycles
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        tick();
        ifu_req_valid = 0;
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t4_wait_busy", {30'b0, busy, ifu_rsp_valid}, 32'b10);
            tick();
        end
        chk("t4_timeout_rsp", {29'b0, ifu_rsp_valid, lsu_rsp_valid, rsp_err}, 32'b101);
        chk("t4_timeout_rdata", rsp_rdata, 32'd0);
        chk("t4_timeout_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("t4_err_width", {31'b0, rsp_err}, 32'd0);

        // response on the timeout cycle wins over the error
        lsu_req_valid = 1; lsu_addr = 32'h8000_0300; lsu_wen = 0;
        tick();
        lsu_req_valid = 0;
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        for (int i = 0; i < 15; i++) tick();
        mem_rsp_valid = 1; mem_rdata = 32'h0000_005A;
        tick();
        mem_rsp_valid = 0; mem_rdata = 32'h0;
        #1;
        chk("t5_late_rsp", {29'b0, ifu_rsp_valid, lsu_rsp_valid, rsp_err}, 32'b010);
        chk("t5_late_rdata", rsp_rdata, 32'h0000_005A);

        // stray response in IDLE
        mem_rsp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        mem_rsp_valid = 0;
        chk("t6_stray_idle", {29'b0, ifu_rsp_valid, lsu_rsp_valid, busy}, 32'd0);
        chk("t6_stray_rdata", rsp_rdata, 32'h0000_005A);

        // reset while in WAIT
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        tick();
        ifu_req_valid = 0;
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        tick();
        rst = 1;
        #1;
        chk("t7_rst_busy", {30'b0, busy, mem_req_valid}, 32'd0);
        chk("t7_rst_mem_addr", mem_addr, 32'd0);
        chk("t7_rst_rdata", rsp_rdata, 32'd0);
        tick();
        rst = 0;
        mem_rsp_valid = 1; mem_rdata = 32'hCAFE_0000;
        tick();
        mem_rsp_valid = 0;
        chk("t7_no_rsp_after", {29'b0, ifu_rsp_valid, lsu_rsp_valid, busy}, 32'd0);
        ifu_req_valid = 1; ifu_addr = 32'h8000_0044;
        #1;
        chk("t7_ready_again", {31'b0, ifu_req_ready}, 32'd1);
        tick();
        ifu_req_valid = 0;
        #1;
        chk("t7_addr_again", mem_addr, 32'h8000_0044);
        mem_serve(32'h0000_0077);
        chk("t7_rsp_again", {29'b0, ifu_rsp_valid, lsu_rsp_valid, rsp_err}, 32'b100);
        chk("t7_rdata_again", rsp_rdata, 32'h0000_0077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
